// File: rtl/shifter_pkg.sv
// Shared definitions for the shift units: FSM encoding and default geometry.
package shifter_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SHW   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_right_unit_if.sv
// Request/response bundle of the iterative right shifter.
interface shift_right_unit_if import shifter_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHW   = DEF_SHW
);

    logic             start;
    logic [WIDTH-1:0] inA;
    logic [SHW-1:0]   inB;
    logic             arith;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (
        output start, inA, inB, arith,
        input  busy, done, out
    );

    modport slave (
        input  start, inA, inB, arith,
        output busy, done, out
    );

endinterface

// File: rtl/shift_right_stage.sv
// One conditional right shift by a power-of-two distance, with selectable fill.
module shift_right_stage import shifter_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHW   = DEF_SHW
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   distance,
    input  logic             enable,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    // Ones-fill is a logical shift of the complement, complemented back.
    always_comb begin
        result = data;
        if (enable) begin
            if (fill) begin
                result = ~((~data) >> distance);
            end else begin
                result = data >> distance;
            end
        end
    end

endmodule

// File: rtl/shift_right_unit.sv
// Iterative SRL/SRA: one shift stage reused for SHW cycles, bit k of the amount per cycle.
module shift_right_unit import shifter_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHW   = DEF_SHW
) (
    input logic               clk,
    input logic               rst,
    shift_right_unit_if.slave bus
);

    state_e           state_q, state_d;
    logic [SHW-1:0]   k_q, k_d;
    logic [SHW-1:0]   amt_q;
    logic             fill_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] out_q;

    logic             load;
    logic             step;
    logic             last;
    logic [SHW-1:0]   distance;
    logic             stage_en;
    logic [WIDTH-1:0] stage_res;

    assign last     = (k_q == SHW'(SHW - 1));
    // distance is one-hot 2^k, so masking the amount selects amount bit k.
    assign distance = SHW'(1) << k_q;
    assign stage_en = |(amt_q & distance);

    shift_right_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .data     (work_q),
        .distance (distance),
        .enable   (stage_en),
        .fill     (fill_q),
        .result   (stage_res)
    );

    // State and stage index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next state: accept start only when not shifting; leave SHIFT after stage SHW-1.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = SHIFT;
                    k_d     = '0;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + SHW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Datapath: latch operands on accept, shift each SHIFT cycle, publish on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amt_q  <= '0;
            fill_q <= 1'b0;
            work_q <= '0;
            out_q  <= '0;
        end else if (load) begin
            amt_q  <= bus.inB;
            fill_q <= bus.arith & bus.inA[WIDTH-1];
            work_q <= bus.inA;
        end else if (step) begin
            work_q <= stage_res;
            if (last) begin
                out_q <= stage_res;
            end
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.out  = out_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed bench for shift_right_unit: vector table plus multi-cycle corner sequences.
module tb_shift_right_unit;
    import shifter_pkg::*;

    localparam int unsigned W  = DEF_WIDTH;
    localparam int unsigned SW = DEF_SHW;
    localparam int          NV = 14;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic        ar;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[NV];

    shift_right_unit_if #(.WIDTH(W), .SHW(SW)) bus ();

    shift_right_unit #(.WIDTH(W), .SHW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge right after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [4:0] b, input logic ar);
        bus.start = 1'b1;
        bus.inA   = a;
        bus.inB   = b;
        bus.arith = ar;
        @(negedge clk);
        bus.start = 1'b0;
        bus.inA   = ~a;
        bus.inB   = ~b;
        bus.arith = ~ar;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bc;
        int pulses;
        int when;
        logic [31:0] got;

        vecs[0]  = '{32'h80000000, 5'd4,  1'b0, 32'h08000000};
        vecs[1]  = '{32'h80000000, 5'd4,  1'b1, 32'hF8000000};
        vecs[2]  = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001};
        vecs[3]  = '{32'hFFFFFFFF, 5'd31, 1'b1, 32'hFFFFFFFF};
        vecs[4]  = '{32'h12345678, 5'd0,  1'b0, 32'h12345678};
        vecs[5]  = '{32'h12345678, 5'd0,  1'b1, 32'h12345678};
        vecs[6]  = '{32'hF0F0F0F0, 5'd3,  1'b0, 32'h1E1E1E1E};
        vecs[7]  = '{32'hF0F0F0F0, 5'd3,  1'b1, 32'hFE1E1E1E};
        vecs[8]  = '{32'h7FFFFFFF, 5'd1,  1'b1, 32'h3FFFFFFF};
        vecs[9]  = '{32'hDEADBEEF, 5'd16, 1'b1, 32'hFFFFDEAD};
        vecs[10] = '{32'hDEADBEEF, 5'd16, 1'b0, 32'h0000DEAD};
        vecs[11] = '{32'hA5A5A5A5, 5'd5,  1'b0, 32'h052D2D2D};
        vecs[12] = '{32'hA5A5A5A5, 5'd5,  1'b1, 32'hFD2D2D2D};
        vecs[13] = '{32'h80000000, 5'd31, 1'b0, 32'h00000001};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.inA   = '0;
        bus.inB   = '0;
        bus.arith = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset out", bus.out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: latency, busy length, result, single-cycle done, result hold.
        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].ar);
            wait_done(cyc, bc);
            check($sformatf("v%0d latency", i), 32'(cyc), 32'd5);
            check($sformatf("v%0d busy cycles", i), 32'(bc), 32'd5);
            check($sformatf("v%0d out", i), bus.out, vecs[i].exp);
            @(negedge clk);
            check($sformatf("v%0d done drop", i), 32'(bus.done), 32'd0);
            check($sformatf("v%0d idle busy", i), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d out hold", i), bus.out, vecs[i].exp);
        end

        // Start during SHIFT is ignored.
        launch(32'h00000100, 5'd8, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.inA   = 32'hFFFFFFFF;
        bus.inB   = 5'd0;
        bus.arith = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        when   = -1;
        got    = '0;
        for (int j = 4; j <= 15; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                when = j;
                got  = bus.out;
            end
        end
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore latency", 32'(when), 32'd5);
        check("ignore out", got, 32'h00000001);

        // Back-to-back start in DONE.
        launch(32'h00000010, 5'd4, 1'b0);
        wait_done(cyc, bc);
        check("b2b first latency", 32'(cyc), 32'd5);
        check("b2b first out", bus.out, 32'h00000001);
        launch(32'h80000000, 5'd31, 1'b1);
        check("b2b no idle busy", 32'(bus.busy), 32'd1);
        check("b2b out held", bus.out, 32'h00000001);
        wait_done(cyc, bc);
        check("b2b done spacing", 32'(cyc + 1), 32'd6);
        check("b2b second out", bus.out, 32'hFFFFFFFF);
        @(negedge clk);

        // Asynchronous reset in the third SHIFT cycle aborts the operation.
        launch(32'hF0000000, 5'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("abort busy before", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort out", bus.out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);

        // First start after reset is accepted immediately.
        launch(32'hC0000000, 5'd2, 1'b1);
        wait_done(cyc, bc);
        check("post reset latency", 32'(cyc), 32'd5);
        check("post reset out", bus.out, 32'hF0000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
